// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, decoder state and key event type.
// Imported by ps2_rx and ps2_keyboard_scanner.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_CAPS = 8'h58;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_t;

  // Keyboard status/ack bytes that never form key events.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE,
      8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: sync, falling-edge detect, 11-bit frame check.
// Ports: clk, clrn, ps2_clk, ps2_data in; byte_strb, rx_byte, parity_err out.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_strb,
  output logic [7:0] rx_byte,
  output logic       parity_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    ck_s;
  logic [1:0]    dt_s;
  logic          ck_h;
  logic          fall;
  logic [3:0]    bcnt;
  logic [9:0]    sh;
  logic [TW-1:0] tcnt;
  logic          frame_ok;

  assign fall = ck_h & ~ck_s[1];

  // start=0, odd parity over data+parity, stop (sampled now)=1
  assign frame_ok = ~sh[0] & (^sh[9:1]) & dt_s[1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ck_s       <= '0;
      dt_s       <= '0;
      ck_h       <= 1'b0;
      bcnt       <= '0;
      sh         <= '0;
      tcnt       <= '0;
      byte_strb  <= 1'b0;
      parity_err <= 1'b0;
      rx_byte    <= '0;
    end else begin
      ck_s       <= {ck_s[0], ps2_clk};
      dt_s       <= {dt_s[0], ps2_data};
      ck_h       <= ck_s[1];
      byte_strb  <= 1'b0;
      parity_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (bcnt == 4'd10) begin
          bcnt       <= '0;
          byte_strb  <= frame_ok;
          parity_err <= ~frame_ok;
          rx_byte    <= sh[8:1];
        end else begin
          sh[bcnt] <= dt_s[1];
          bcnt     <= bcnt + 4'd1;
        end
      end else if (bcnt != '0) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bcnt <= '0;
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_scanner.sv
// PS/2 keyboard scanner: prefix decoder, capslock, make-event FIFO.
// Ports: PS/2 in, rd_en pop; FIFO head, key state and status flags out.
module ps2_keyboard_scanner
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int REPEAT_EN      = 0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       key_valid,
  output logic       key_down,
  output logic       capslock,
  output logic       parity_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          byte_strb;
  logic [7:0]    rx_byte;
  dec_state_t    state;
  dec_state_t    nstate;
  logic          make_ev;
  logic          brk_ev;
  key_t          ev;
  key_t          lm;
  logic          lm_vld;
  logic          rpt;
  logic          push;
  logic          toggle;
  logic          pop;
  logic          full;
  logic          wr;
  key_t          mem [FIFO_DEPTH];
  key_t          head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_strb (byte_strb),
    .rx_byte   (rx_byte),
    .parity_err(parity_err)
  );

  always_comb begin
    nstate  = state;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev      = '{ext: 1'b0, code: rx_byte};
    if (byte_strb) begin
      unique case (state)
        IDLE: begin
          if (rx_byte == PS2_EXT) begin
            nstate = EXT;
          end else if (rx_byte == PS2_BRK) begin
            nstate = BRK;
          end else if (!is_ignored(rx_byte)) begin
            make_ev = 1'b1;
          end
        end
        EXT: begin
          if (rx_byte == PS2_BRK) begin
            nstate = EXT_BRK;
          end else begin
            make_ev = 1'b1;
            ev.ext  = 1'b1;
            nstate  = IDLE;
          end
        end
        BRK: begin
          brk_ev = 1'b1;
          nstate = IDLE;
        end
        EXT_BRK: begin
          brk_ev = 1'b1;
          ev.ext = 1'b1;
          nstate = IDLE;
        end
        default: nstate = IDLE;
      endcase
    end
  end

  assign rpt    = lm_vld && (lm == ev);
  assign push   = make_ev && ((REPEAT_EN != 0) || !rpt);
  assign toggle = make_ev && !rpt && !ev.ext
               && (ev.code == PS2_CAPS);

  assign key_valid = (cnt != '0);
  assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
  assign pop       = rd_en && key_valid;
  // A full FIFO still accepts when the head leaves the same cycle.
  assign wr        = push && (!full || pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      capslock <= 1'b0;
      lm       <= '0;
      lm_vld   <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      if (toggle) begin
        capslock <= ~capslock;
      end
      if (push) begin
        lm     <= ev;
        lm_vld <= 1'b1;
      end else if (brk_ev && lm_vld && (lm == ev)) begin
        lm_vld <= 1'b0;
      end
      if (wr) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[wptr] <= ev;
    end
  end

  assign head     = mem[rptr];
  assign key_down = lm_vld;
  assign scancode = key_valid ? head.code : 8'h00;
  assign extended = key_valid ? head.ext : 1'b0;

endmodule

// File: tb/tb_ps2_keyboard_scanner.sv
// Self-checking bench for ps2_keyboard_scanner.
// Scoreboard queue of expected make events, popped on FIFO reads.
module tb_ps2_keyboard_scanner;

  localparam int TO = 300;
  localparam int HB = 10;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic [7:0] scancode;
  logic       extended;
  logic       key_valid;
  logic       key_down;
  logic       capslock;
  logic       parity_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [8:0] expq[$];
  logic       kv_at [1:6];
  logic       pe_at [1:6];

  ps2_keyboard_scanner #(
    .FIFO_DEPTH    (8),
    .TIMEOUT_CYCLES(TO),
    .REPEAT_EN     (0)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .scancode  (scancode),
    .extended  (extended),
    .key_valid (key_valid),
    .key_down  (key_down),
    .capslock  (capslock),
    .parity_err(parity_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] frame(
    input logic [7:0] b, input logic badpar);
    return {1'b1, (~(^b)) ^ badpar, b, 1'b0};
  endfunction

  // Sends the first n bits of f; on the stop bit, records
  // key_valid/parity_err after each of the next 6 posedges.
  task automatic send_bits(input logic [10:0] f,
                           input int n, input bit pop_mid);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HB) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int k = 1; k <= 6; k++) begin
          @(posedge clk);
          #1;
          kv_at[k] = key_valid;
          pe_at[k] = parity_err;
          if (pop_mid && k == 3) rd_en = 1'b1;
          if (pop_mid && k == 4) rd_en = 1'b0;
        end
      end
      repeat (HB) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(frame(b, 1'b0), 11, 1'b0);
  endtask

  task automatic pop_head();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    rd_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({scancode, extended, key_valid, key_down,
         capslock, parity_err, overflow} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
        {scancode, extended, key_valid, key_down,
         capslock, parity_err, overflow});
    end
    clrn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_make_break();
    logic [8:0] e;
    expq.push_back({1'b0, 8'h1C});
    send(8'h1C);
    checks++;
    if (kv_at[3] !== 1'b0 || kv_at[4] !== 1'b1) begin
      errors++;
      $display("FAIL make_latency got %b%b want 01",
        kv_at[3], kv_at[4]);
    end
    checks++;
    if ({key_valid, extended, scancode, key_down}
        !== {1'b1, 1'b0, 8'h1C, 1'b1}) begin
      errors++;
      $display("FAIL make_1c got v%b e%b %h d%b want v1 e0 1c d1",
        key_valid, extended, scancode, key_down);
    end
    send(8'hF0);
    send(8'h1C);
    checks++;
    if (key_down !== 1'b0) begin
      errors++;
      $display("FAIL break_1c key_down got %b want 0", key_down);
    end
    e = expq.pop_front();
    checks++;
    if ({key_valid, extended, scancode} !== {1'b1, e}) begin
      errors++;
      $display("FAIL head_1c got v%b %h want v1 %h",
        key_valid, {extended, scancode}, e);
    end
    pop_head();
    checks++;
    if (key_valid !== 1'b0 || scancode !== 8'h00) begin
      errors++;
      $display("FAIL empty_after_pop got v%b %h want v0 00",
        key_valid, scancode);
    end
  endtask

  task automatic test_capslock();
    logic [8:0] e;
    int n;
    expq.push_back({1'b0, 8'h58});
    send(8'h58); send(8'hF0); send(8'h58);
    checks++;
    if (capslock !== 1'b1) begin
      errors++;
      $display("FAIL caps_on got %b want 1", capslock);
    end
    expq.push_back({1'b0, 8'h58});
    send(8'h58); send(8'hF0); send(8'h58);
    checks++;
    if (capslock !== 1'b0) begin
      errors++;
      $display("FAIL caps_off got %b want 0", capslock);
    end
    expq.push_back({1'b0, 8'h58});
    send(8'h58); send(8'h58);
    checks++;
    if (capslock !== 1'b1 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL caps_held got c%b d%b want c1 d1",
        capslock, key_down);
    end
    send(8'hF0); send(8'h58);
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      e = expq.pop_front();
      checks++;
      if ({key_valid, extended, scancode} !== {1'b1, e}) begin
        errors++;
        $display("FAIL caps_pop%0d got v%b %h want v1 %h",
          i, key_valid, {extended, scancode}, e);
      end
      pop_head();
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL caps_count got v%b want 0", key_valid);
    end
  endtask

  task automatic test_extended();
    logic [8:0] e;
    expq.push_back({1'b1, 8'h75});
    send(8'hE0); send(8'h75);
    checks++;
    if (key_down !== 1'b1) begin
      errors++;
      $display("FAIL ext_down got %b want 1", key_down);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++;
    if (key_down !== 1'b0) begin
      errors++;
      $display("FAIL ext_up got %b want 0", key_down);
    end
    e = expq.pop_front();
    checks++;
    if ({key_valid, extended, scancode} !== {1'b1, e}) begin
      errors++;
      $display("FAIL ext_head got v%b %h want v1 %h",
        key_valid, {extended, scancode}, e);
    end
    pop_head();
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL ext_count got v%b want 0", key_valid);
    end
  endtask

  task automatic test_parity();
    logic [8:0] e;
    send_bits(frame(8'h1C, 1'b1), 11, 1'b0);
    checks++;
    if ({pe_at[2], pe_at[3], pe_at[4]} !== 3'b010) begin
      errors++;
      $display("FAIL parity_pulse got %b%b%b want 010",
        pe_at[2], pe_at[3], pe_at[4]);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_drop got v%b want 0", key_valid);
    end
    expq.push_back({1'b0, 8'h1C});
    send(8'h1C);
    e = expq.pop_front();
    checks++;
    if ({key_valid, extended, scancode} !== {1'b1, e}) begin
      errors++;
      $display("FAIL parity_next got v%b %h want v1 %h",
        key_valid, {extended, scancode}, e);
    end
    pop_head();
    send(8'hF0); send(8'h1C);
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    logic [8:0] e;
    int n;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
              8'h35, 8'h3C, 8'h43, 8'h44};
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expq.push_back({1'b0, codes[i]});
      send(codes[i]);
      if (i == 7) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got %b want 0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b want 1", overflow);
    end
    e = expq.pop_front();
    checks++;
    if ({extended, scancode} !== e) begin
      errors++;
      $display("FAIL ovf_head got %h want %h",
        {extended, scancode}, e);
    end
    expq.push_back({1'b0, 8'h4B});
    send_bits(frame(8'h4B, 1'b0), 11, 1'b1);
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      e = expq.pop_front();
      checks++;
      if ({key_valid, extended, scancode} !== {1'b1, e}) begin
        errors++;
        $display("FAIL ovf_pop%0d got v%b %h want v1 %h",
          i, key_valid, {extended, scancode}, e);
      end
      pop_head();
    end
    checks++;
    if (key_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count got v%b o%b want v0 o1",
        key_valid, overflow);
    end
  endtask

  task automatic test_timeout();
    logic [8:0] e;
    send_bits(frame(8'h1C, 1'b0), 5, 1'b0);
    repeat (TO + 1) @(negedge clk);
    expq.push_back({1'b0, 8'h1C});
    send(8'h1C);
    checks++;
    if ({pe_at[1], pe_at[2], pe_at[3],
         pe_at[4], pe_at[5], pe_at[6]} !== 6'b0) begin
      errors++;
      $display("FAIL timeout_perr got %b%b%b%b%b%b want 0",
        pe_at[1], pe_at[2], pe_at[3],
        pe_at[4], pe_at[5], pe_at[6]);
    end
    e = expq.pop_front();
    checks++;
    if ({key_valid, extended, scancode} !== {1'b1, e}) begin
      errors++;
      $display("FAIL timeout_rx got v%b %h want v1 %h",
        key_valid, {extended, scancode}, e);
    end
    pop_head();
  endtask

  task automatic test_reset_midframe();
    send(8'h2D);
    send_bits(frame(8'h3C, 1'b0), 4, 1'b0);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    checks++;
    if ({scancode, extended, key_valid, key_down,
         capslock, parity_err, overflow} !== 14'h0) begin
      errors++;
      $display("FAIL midframe_reset got %h want 0",
        {scancode, extended, key_valid, key_down,
         capslock, parity_err, overflow});
    end
    expq.delete();
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h1C);
    checks++;
    if ({key_valid, extended, scancode, overflow}
        !== {1'b1, 1'b0, 8'h1C, 1'b0}) begin
      errors++;
      $display("FAIL post_reset got v%b e%b %h o%b want v1 e0 1c o0",
        key_valid, extended, scancode, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_capslock();
    test_extended();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
